fifo: RTL and testbench

Byte-in, halfword-out FIFO between the UART receiver and the SRAM writer in the uart2sram path. Accepts 8-bit bytes on rising edges of a write strobe, packs consecutive byte pairs into 16-bit words, and releases one word per rising edge of a read strobe. Capacity is 32 bytes (16 words). Status outputs report empty, full and the count of complete words.

---
 rtl/fifo_pkg.sv | 5 +
 rtl/fifo_edge_detect.sv | 18 +
 rtl/fifo.sv | 81 ++++++++
 tb/tb_fifo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the byte-in / halfword-out FIFO.
package fifo_pkg;
  localparam int DEPTH_BYTES = 32;
  localparam int WORDS       = 16;
endpackage

// File: rtl/fifo_edge_detect.sv
// Rising-edge detector for a level strobe. While in reset the history
// register tracks the live level, so a strobe already high when reset
// releases does not produce a pulse.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic level_q;

  // Remember the previous-cycle strobe level (loads current level in reset).
  always_ff @(posedge clk) begin
    level_q <= level;
  end

  assign pulse = level & ~level_q & ~rst;
endmodule

// File: rtl/fifo.sv
// Byte-in, halfword-out FIFO: bytes are packed big-endian into 16-bit
// words, one word leaves per rising edge of the read strobe.
module fifo
  import fifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        en_write,
  input  logic        en_read,
  output logic [15:0] data_out,
  output logic        empty,
  output logic        full,
  output logic [4:0]  data_cnt
);
  logic [7:0]  mem [DEPTH_BYTES];
  logic [4:0]  wr_ptr_reg;
  logic [3:0]  rd_ptr_reg;
  logic [5:0]  byte_cnt_reg;
  logic [5:0]  byte_cnt_next;
  logic [15:0] data_out_reg;
  logic        wr_edge;
  logic        rd_edge;
  logic        wr_ok;
  logic        rd_ok;

  edge_detect u_wr_edge (
    .clk   (clk),
    .rst   (rst),
    .level (en_write),
    .pulse (wr_edge)
  );

  edge_detect u_rd_edge (
    .clk   (clk),
    .rst   (rst),
    .level (en_read),
    .pulse (rd_edge)
  );

  // Acceptance uses the pre-cycle flags: a read freeing space does not
  // unblock a write in the same cycle.
  assign wr_ok = wr_edge & ~full;
  assign rd_ok = rd_edge & ~empty;

  // Byte count moves +1 per write, -2 per read (net -1 when both happen).
  always_comb begin
    byte_cnt_next = byte_cnt_reg + {5'd0, wr_ok} - {4'd0, rd_ok, 1'b0};
  end

  // Byte storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Pointers, byte count and the registered output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      byte_cnt_reg <= '0;
      data_out_reg <= '0;
    end else begin
      byte_cnt_reg <= byte_cnt_next;
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 5'd1;
      end
      if (rd_ok) begin
        data_out_reg <= {mem[{rd_ptr_reg, 1'b0}], mem[{rd_ptr_reg, 1'b1}]};
        rd_ptr_reg   <= rd_ptr_reg + 4'd1;
      end
    end
  end

  assign data_out = data_out_reg;
  assign data_cnt = byte_cnt_reg[5:1];
  assign empty    = (byte_cnt_reg < 6'd2);
  assign full     = (byte_cnt_reg == 6'(DEPTH_BYTES));
endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: read stimulus pushes the expected word, a
// monitor pops and compares once the DUT has registered the read.
module tb_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        en_write;
  logic        en_read;
  logic [15:0] data_out;
  logic        empty;
  logic        full;
  logic [4:0]  data_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  event rd_ev;

  fifo dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .en_write (en_write),
    .en_read  (en_read),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .data_cnt (data_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: compare each presented read result with the scoreboard head.
  initial begin
    forever begin
      @(rd_ev);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got %h, expected nothing queued", data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", data_out, e);
        end else begin
          $display("read  data_out=%h ok", data_out);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: bench did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_status(input string name, input int cnt, input int e, input int f);
    chk({name, "_cnt"}, int'(data_cnt), cnt);
    chk({name, "_empty"}, int'(empty), e);
    chk({name, "_full"}, int'(full), f);
  endtask

  // Strobe held three cycles, then one low cycle.
  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    en_write = 1'b1;
    data_in  = b;
    repeat (3) @(negedge clk);
    en_write = 1'b0;
    @(negedge clk);
    $display("write data_in=%h cnt=%0d", b, data_cnt);
  endtask

  task automatic read_word(input logic [15:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    en_read = 1'b1;
    @(negedge clk);
    -> rd_ev;
    repeat (2) @(negedge clk);
    en_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] fill_bytes [32];

  initial begin
    rst = 1'b1; en_write = 1'b1; en_read = 1'b0; data_in = 8'h77;
    // Reset with write strobe held high.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_status("reset", 0, 1, 0);
    chk("reset_dout", int'(data_out), 0);
    en_write = 1'b0;
    @(negedge clk);
    // One real byte: a spurious enqueue during reset would make a word.
    write_byte(8'h99);
    chk_status("no_spurious", 0, 1, 0);
    // Reset discards the pending odd byte.
    do_reset();
    chk_status("reset2", 0, 1, 0);
    write_byte(8'h01);
    write_byte(8'h02);
    read_word(16'h0102);
    do_reset();

    // Fill.
    for (int i = 0; i < 32; i++) fill_bytes[i] = 8'h15;
    fill_bytes[16] = 8'h2D; fill_bytes[18] = 8'h4C;
    fill_bytes[20] = 8'h59; fill_bytes[24] = 8'h41;
    for (int i = 0; i < 32; i++) begin
      write_byte(fill_bytes[i]);
      chk_status("fill", (i + 1) / 2, (i == 0) ? 1 : 0, (i == 31) ? 1 : 0);
    end
    // Overflow.
    write_byte(8'hFF);
    chk_status("overflow", 16, 0, 1);
    // Drain.
    for (int w = 0; w < 8; w++) read_word(16'h1515);
    read_word(16'h2D15); read_word(16'h4C15); read_word(16'h5915);
    read_word(16'h1515); read_word(16'h4115); read_word(16'h1515);
    read_word(16'h1515); read_word(16'h1515);
    chk_status("drained", 0, 1, 0);
    read_word(16'h1515);  // read on empty holds data_out
    chk_status("rd_empty", 0, 1, 0);

    // Odd byte and simultaneous ops.
    write_byte(8'hAB); write_byte(8'hCD); write_byte(8'hEF);
    chk_status("odd", 1, 0, 0);
    exp_q.push_back(16'hABCD);
    @(negedge clk);
    en_read = 1'b1; en_write = 1'b1; data_in = 8'h12;
    @(negedge clk);
    -> rd_ev;
    chk_status("simul", 1, 0, 0);
    en_read = 1'b0; en_write = 1'b0;
    @(negedge clk);
    read_word(16'hEF12);
    chk_status("simul_after", 0, 1, 0);

    // Wrap-around rounds.
    for (int r = 0; r < 3; r++) begin
      logic [7:0] b0, b1;
      for (int i = 0; i < 32; i++) write_byte(8'((r * 37 + i * 3) & 8'hFF));
      chk_status("wrap_full", 16, 0, 1);
      for (int k = 0; k < 16; k++) begin
        b0 = 8'((r * 37 + (2 * k) * 3) & 8'hFF);
        b1 = 8'((r * 37 + (2 * k + 1) * 3) & 8'hFF);
        read_word({b0, b1});
      end
      chk_status("wrap_empty", 0, 1, 0);
    end

    repeat (2) @(negedge clk);
    chk("queue_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
